// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan path.
package seg_pkg;

    localparam int         SEG_PWM_STEPS = 16;
    localparam logic [3:0] SEG_BLANK_NIB = 4'h0;

    // One captured digit: nibble plus its show/blink attributes.
    typedef struct packed {
        logic [3:0] nib;
        logic       vld;
        logic       blk;
    } seg_digit_t;

    function automatic int seg_aw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timebase: per-slot phase, digit slot, frame counter, blink phase,
// frame-boundary strobe and PWM duty enable.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter  int SCAN_DIV     = 250000,
    parameter  int NUM_DIGITS   = 8,
    parameter  int BLINK_FRAMES = 64,
    localparam int AW           = seg_aw(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    brightness_i,
    output logic [AW-1:0] slot_o,
    output logic          fb_o,
    output logic          blink_ph_o,
    output logic          pwm_en_o
);

    localparam int          PW   = $clog2(SCAN_DIV);
    localparam int          FW   = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES);
    localparam int unsigned STEP = SCAN_DIV / SEG_PWM_STEPS;

    localparam logic [PW-1:0] PH_MAX = PW'(SCAN_DIV - 1);
    localparam logic [AW-1:0] SL_MAX = AW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FR_MAX = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic [AW-1:0] slot_q, slot_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic          ph_wrap, fb;
    logic [31:0]   duty_thr;

    assign ph_wrap = (phase_q == PH_MAX);
    assign fb      = ph_wrap && (slot_q == SL_MAX);

    always_comb begin
        phase_d     = phase_q + 1'b1;
        slot_d      = slot_q;
        frame_cnt_d = frame_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (ph_wrap) begin
            phase_d = '0;
            // Explicit wrap keeps slot legal for non-power-of-two digit counts.
            slot_d  = (slot_q == SL_MAX) ? '0 : slot_q + 1'b1;
        end
        if (fb) begin
            if (frame_cnt_q == FR_MAX) begin
                frame_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= '0;
            slot_q      <= '0;
            frame_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            slot_q      <= slot_d;
            frame_cnt_q <= frame_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    // Brightness is live: duty window is (brightness+1) sixteenths of the slot.
    assign duty_thr   = STEP * (32'(brightness_i) + 32'd1);
    assign pwm_en_o   = (32'(phase_q) < duty_thr);
    assign slot_o     = slot_q;
    assign fb_o       = fb;
    assign blink_ph_o = blink_ph_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-synchronous
// loading, per-digit blank/blink and 16-level PWM brightness.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter  int NUM_DIGITS   = 8,
    parameter  int SCAN_DIV     = 250000,
    parameter  int BLINK_FRAMES = 64,
    localparam int AW           = seg_aw(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] output_data,
    input  logic [NUM_DIGITS-1:0]   output_valid,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    load,
    input  logic [3:0]              brightness,
    output logic [3:0]              seg_data,
    output logic [AW-1:0]           seg_an,
    output logic                    seg_en
);

    seg_digit_t [NUM_DIGITS-1:0] in_w;
    seg_digit_t [NUM_DIGITS-1:0] pend_q, pend_d;
    seg_digit_t [NUM_DIGITS-1:0] shad_q, shad_d;
    seg_digit_t                  cur;
    logic                        pend_vld_q, pend_vld_d;

    logic [AW-1:0] slot;
    logic          fb, blink_ph, pwm_en;
    logic [3:0]    seg_data_q, seg_data_d;
    logic [AW-1:0] seg_an_q, seg_an_d;
    logic          seg_en_q, seg_en_d;

    seg_scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .NUM_DIGITS   (NUM_DIGITS),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .brightness_i (brightness),
        .slot_o       (slot),
        .fb_o         (fb),
        .blink_ph_o   (blink_ph),
        .pwm_en_o     (pwm_en)
    );

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_dig
        assign in_w[g] = '{nib: output_data[4*g +: 4],
                           vld: output_valid[g],
                           blk: blink_mask[g]};
    end

    // A load on the boundary cycle bypasses pending so it still lands next frame.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        shad_d     = shad_q;
        if (fb) begin
            if (load) begin
                shad_d = in_w;
            end else if (pend_vld_q) begin
                shad_d = pend_q;
            end
            pend_vld_d = 1'b0;
        end else if (load) begin
            pend_d     = in_w;
            pend_vld_d = 1'b1;
        end
    end

    always_comb begin
        cur        = shad_q[slot];
        seg_an_d   = slot;
        seg_data_d = cur.vld ? cur.nib : SEG_BLANK_NIB;
        seg_en_d   = cur.vld && !(cur.blk && blink_ph) && pwm_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            shad_q     <= '0;
            seg_data_q <= '0;
            seg_an_q   <= '0;
            seg_en_q   <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            shad_q     <= shad_d;
            seg_data_q <= seg_data_d;
            seg_an_q   <= seg_an_d;
            seg_en_q   <= seg_en_d;
        end
    end

    assign seg_data = seg_data_q;
    assign seg_an   = seg_an_q;
    assign seg_en   = seg_en_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a frame-level reference model.
module tb_seg_scan_ctrl;

    localparam int DIV = 16;
    localparam int N   = 4;
    localparam int BF  = 2;
    localparam int FL  = DIV * N;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] output_data = '0;
    logic [3:0]  output_valid = '0;
    logic [3:0]  blink_mask = '0;
    logic        load = 1'b0;
    logic [3:0]  brightness = 4'd15;
    logic [3:0]  seg_data;
    logic [1:0]  seg_an;
    logic        seg_en;

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (DIV),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .output_data  (output_data),
        .output_valid (output_valid),
        .blink_mask   (blink_mask),
        .load         (load),
        .brightness   (brightness),
        .seg_data     (seg_data),
        .seg_an       (seg_an),
        .seg_en       (seg_en)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n      = 0;   // scan cycles consumed since reset released

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: the shadow seen in frame f is the latest load issued on or
    // before the last cycle of frame f-1; a reset forgets all loads.
    typedef struct {
        int          idx;
        logic [15:0] d;
        logic [3:0]  v;
        logic [3:0]  m;
    } ld_t;
    ld_t lq[$];

    int          m_ph, m_sl, m_f;
    logic [15:0] m_sd;
    logic [3:0]  m_sv, m_sm;
    logic        m_bph;
    logic [3:0]  e_d;
    logic [1:0]  e_an;
    logic        e_en;

    always @(posedge clk) begin
        if (rst) begin
            lq.delete();
            n    = 0;
            e_d  = '0;
            e_an = '0;
            e_en = 1'b0;
        end else begin
            m_ph = n % DIV;
            m_sl = (n / DIV) % N;
            m_f  = n / FL;
            m_sd = '0; m_sv = '0; m_sm = '0;
            foreach (lq[i]) begin
                if (lq[i].idx <= m_f * FL - 1) begin
                    m_sd = lq[i].d; m_sv = lq[i].v; m_sm = lq[i].m;
                end
            end
            m_bph = ((m_f / BF) % 2) == 1;
            e_an  = 2'(m_sl);
            e_d   = m_sv[m_sl] ? m_sd[4*m_sl +: 4] : 4'h0;
            e_en  = m_sv[m_sl] && !(m_sm[m_sl] && m_bph) &&
                    (m_ph < (DIV / 16) * (int'(brightness) + 1));
            if (load) lq.push_back('{idx: n, d: output_data, v: output_valid, m: blink_mask});
            n++;
        end
        #1;
        chk("model seg_an", 32'(seg_an), 32'(e_an));
        chk("model seg_data", 32'(seg_data), 32'(e_d));
        chk("model seg_en", 32'(seg_en), 32'(e_en));
    end

    task automatic wait_n(input int x);
        int g = 0;
        while (n != x && g < 4000) begin
            @(negedge clk);
            g++;
        end
        if (n != x) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_n: reached %0d expected %0d", n, x);
        end
    endtask

    // Literal expectation for the outputs produced from scan cycle x.
    task automatic at_state(input int x, input string nm, input logic [3:0] d,
                            input logic [1:0] an, input logic en);
        wait_n(x + 1);
        chk({nm, " an"}, 32'(seg_an), 32'(an));
        chk({nm, " data"}, 32'(seg_data), 32'(d));
        chk({nm, " en"}, 32'(seg_en), 32'(en));
    endtask

    task automatic do_load(input int x, input logic [15:0] d, input logic [3:0] v,
                           input logic [3:0] m);
        wait_n(x);
        output_data  = d;
        output_valid = v;
        blink_mask   = m;
        load         = 1'b1;
        @(negedge clk);
        load         = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset an", 32'(seg_an), 32'd0);
        chk("reset data", 32'(seg_data), 32'd0);
        chk("reset en", 32'(seg_en), 32'd0);
        rst = 1'b0;

        // Empty shadow: slots still step, digits stay dark.
        at_state(16, "empty s1", 4'h0, 2'd1, 1'b0);
        at_state(48, "empty s3", 4'h0, 2'd3, 1'b0);
        at_state(64, "empty wrap", 4'h0, 2'd0, 1'b0);

        // Mid-slot-1 load appears only from the next frame.
        do_load(88, 16'h4321, 4'hF, 4'h0);
        at_state(100, "pre-sync", 4'h0, 2'd2, 1'b0);
        at_state(128, "sync d0", 4'h1, 2'd0, 1'b1);
        at_state(165, "sync d2", 4'h3, 2'd2, 1'b1);
        at_state(176, "sync d3", 4'h4, 2'd3, 1'b1);

        // Blanking and minimum/maximum brightness.
        do_load(180, 16'h4321, 4'b0101, 4'h0);
        brightness = 4'd0;
        at_state(192, "dim d0 on", 4'h1, 2'd0, 1'b1);
        at_state(193, "dim d0 off", 4'h1, 2'd0, 1'b0);
        at_state(208, "blank d1", 4'h0, 2'd1, 1'b0);
        at_state(224, "dim d2 on", 4'h3, 2'd2, 1'b1);
        at_state(225, "dim d2 off", 4'h3, 2'd2, 1'b0);
        brightness = 4'd15;
        at_state(239, "full d2 end", 4'h3, 2'd2, 1'b1);
        at_state(271, "full d0 end", 4'h1, 2'd0, 1'b1);

        // Blink on digit 1: dark in frames 2-3 and 6-7 of each 4-frame cycle.
        do_load(300, 16'h4321, 4'hF, 4'b0010);
        at_state(339, "blink lit f5", 4'h2, 2'd1, 1'b1);
        at_state(387, "steady d0 f6", 4'h1, 2'd0, 1'b1);
        at_state(403, "blink dark f6", 4'h2, 2'd1, 1'b0);
        at_state(472, "blink dark f7", 4'h2, 2'd1, 1'b0);
        at_state(532, "blink lit f8", 4'h2, 2'd1, 1'b1);

        // Two mid-frame loads then one on the boundary cycle: last one shows.
        do_load(540, 16'hAAAA, 4'hF, 4'h0);
        do_load(560, 16'hBBBB, 4'hF, 4'h0);
        do_load(575, 16'hCCCC, 4'hF, 4'h0);
        at_state(581, "fb load d0", 4'hC, 2'd0, 1'b1);
        at_state(600, "fb load d1", 4'hC, 2'd1, 1'b1);

        // Reset with a load pending: it must never surface.
        do_load(605, 16'hDDDD, 4'hF, 4'h0);
        wait_n(610);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        at_state(69, "post-rst f1", 4'h0, 2'd0, 1'b0);
        at_state(130, "post-rst f2", 4'h0, 2'd0, 1'b0);
        at_state(180, "post-rst s3", 4'h0, 2'd3, 1'b0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
